// File: rtl/bicubic_pkg.sv
// Shared definitions for the bicubic tap window: pixel and weight widths,
// window controller state encodings and the per-phase weight table.
package bicubic_pkg;

  localparam int unsigned PIX_W = 9;
  localparam int unsigned WGT_W = 4;
  localparam int unsigned TAPS  = 4;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_FLUSH = 2'd2
  } tap_state_e;

  // Weights are sign-magnitude {sign,mag[2:0]}, indexed [phase][tap] with tap 0 = w1 (x-1).
  localparam logic [WGT_W-1:0] W_TAB [4][4] = '{
    '{4'h0, 4'h7, 4'h0, 4'h0},
    '{4'hB, 4'h6, 4'h4, 4'h9},
    '{4'h9, 4'h5, 4'h5, 4'h9},
    '{4'h9, 4'h4, 4'h6, 4'hB}
  };

  // Packs one table row as {w4,w3,w2,w1} so w1 lands in the low nibble.
  function automatic logic [TAPS*WGT_W-1:0] pack_weights(input logic [1:0] idx);
    return {W_TAB[idx][3], W_TAB[idx][2], W_TAB[idx][1], W_TAB[idx][0]};
  endfunction

endpackage

// File: rtl/bicubic_weight_rom.sv
// Phase-to-weight lookup for the tap window. Pure combinational.
// The table holds four phase rows; for other upscale factors each phase is
// mapped onto the nearest-below quarter position (phase*4/SCALE).
module bicubic_weight_rom
  import bicubic_pkg::*;
#(
  parameter int unsigned SCALE = 4
) (
  input  logic [2:0]             phase_i,
  output logic [TAPS*WGT_W-1:0]  weights_o
);

  logic [4:0] phaseX4;
  logic [4:0] quarter;

  // Scale the phase into table rows and fetch the packed weight vector.
  always_comb begin
    phaseX4   = {phase_i, 2'b00};
    quarter   = phaseX4 / 5'(SCALE);
    weights_o = pack_weights(2'(quarter));
  end

endmodule

// File: rtl/bicubic_tap_window.sv
// Streaming 4-tap window generator for one bicubic axis pass.
// Collects line pixels into a shift window with edge replication at both ends
// and, for every centre pixel, presents SCALE windows {x-1,x,x+1,x+2} along
// with the phase weights. Optional stall counter: define
// BICUBIC_TAP_STALL_CNT_EN to add the stall_cnt output.
module bicubic_tap_window #(
  parameter int unsigned SCALE = 4,
  parameter int unsigned PIX_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_data,
  input  logic               in_sol,
  input  logic               in_eol,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*PIX_W-1:0] out_pixels,
  output logic [15:0]        out_weights,
  output logic [2:0]         out_phase,
  output logic               out_sol,
  output logic               out_eol
`ifdef BICUBIC_TAP_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  import bicubic_pkg::*;

  tap_state_e         state_q, state_d;
  logic [2:0]         fill_q, fill_d;
  logic [1:0]         pend_q, pend_d;
  logic [2:0]         phase_q, phase_d;
  logic               firstCentre_q, firstCentre_d;
  logic               eolSeen_q, eolSeen_d;
  logic [4*PIX_W-1:0] win_q, win_d;
  logic [15:0]        weights_q, weights_d;
  logic [15:0]        romWeights;
  logic [PIX_W-1:0]   lastPix;
  logic               accept;
  logic               lastPhase;

  bicubic_weight_rom #(
    .SCALE(SCALE)
  ) u_weight_rom (
    .phase_i   (phase_d),
    .weights_o (romWeights)
  );

  assign in_ready    = (state_q == ST_FILL);
  assign accept      = in_valid && in_ready;
  assign lastPix     = win_q[4*PIX_W-1 -: PIX_W];
  assign lastPhase   = (phase_q == 3'(SCALE - 1));
  assign out_valid   = (state_q == ST_EMIT);
  assign out_pixels  = win_q;
  assign out_weights = weights_q;
  assign out_phase   = phase_q;
  assign out_sol     = out_valid && (phase_q == 3'd0) && firstCentre_q;
  assign out_eol     = out_valid && lastPhase && eolSeen_q && (pend_q == 2'd0);

  // Weights only reload when a window is about to be presented, so they stay
  // at their reset value until the first window and freeze during a stall.
  assign weights_d = (state_d == ST_EMIT) ? romWeights : weights_q;

  // Window controller: fill the shift window, emit SCALE phases per centre,
  // then replicate the last pixel twice at end of line to finish the edge.
  always_comb begin
    state_d       = state_q;
    fill_d        = fill_q;
    pend_d        = pend_q;
    phase_d       = phase_q;
    firstCentre_d = firstCentre_q;
    eolSeen_d     = eolSeen_q;
    win_d         = win_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (in_sol) begin
            win_d         = {in_data, in_data, {(2*PIX_W){1'b0}}};
            fill_d        = 3'd2;
            firstCentre_d = 1'b1;
            eolSeen_d     = in_eol;
            pend_d        = in_eol ? 2'd2 : 2'd0;
            phase_d       = 3'd0;
            state_d       = in_eol ? ST_FLUSH : ST_FILL;
          end else if (fill_q != 3'd0) begin
            win_d  = {in_data, win_q[4*PIX_W-1:PIX_W]};
            fill_d = fill_q + 3'd1;
            if (in_eol) begin
              eolSeen_d = 1'b1;
              pend_d    = 2'd2;
            end
            if (fill_q == 3'd3) begin
              state_d = ST_EMIT;
            end else if (in_eol) begin
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        win_d   = {lastPix, win_q[4*PIX_W-1:PIX_W]};
        phase_d = 3'd0;
        if (pend_q != 2'd0) begin
          pend_d = pend_q - 2'd1;
        end
        if (fill_q >= 3'd3) begin
          fill_d  = 3'd4;
          state_d = ST_EMIT;
        end else begin
          fill_d = fill_q + 3'd1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (lastPhase) begin
            phase_d       = 3'd0;
            firstCentre_d = 1'b0;
            if (pend_q != 2'd0) begin
              state_d = ST_FLUSH;
            end else begin
              state_d = ST_FILL;
              if (eolSeen_q) begin
                fill_d    = 3'd0;
                eolSeen_d = 1'b0;
              end else begin
                fill_d = 3'd3;
              end
            end
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State, window and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_FILL;
      fill_q        <= 3'd0;
      pend_q        <= 2'd0;
      phase_q       <= 3'd0;
      firstCentre_q <= 1'b0;
      eolSeen_q     <= 1'b0;
      win_q         <= '0;
      weights_q     <= '0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      pend_q        <= pend_d;
      phase_q       <= phase_d;
      firstCentre_q <= firstCentre_d;
      eolSeen_q     <= eolSeen_d;
      win_q         <= win_d;
      weights_q     <= weights_d;
    end
  end

`ifdef BICUBIC_TAP_STALL_CNT_EN
  logic [15:0] stallCnt_q;

  // Count cycles a window waits on downstream, saturating at all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt_q <= 16'h0000;
    end else if (out_valid && !out_ready && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_q <= stallCnt_q + 16'h0001;
    end
  end

  assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_bicubic_tap_window.sv
// Directed testbench for bicubic_tap_window with SCALE=4, PIX_W=9.
// Inputs are driven 1 time unit after the rising edge; outputs are observed
// on the falling edge, where they equal the values the next rising edge sees.
module tb_bicubic_tap_window;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_data = '0;
  logic        in_sol = 1'b0;
  logic        in_eol = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [35:0] out_pixels;
  logic [15:0] out_weights;
  logic [2:0]  out_phase;
  logic        out_sol;
  logic        out_eol;
`ifdef BICUBIC_TAP_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  typedef struct packed {
    logic [35:0] pix;
    logic [15:0] wgt;
    logic [2:0]  ph;
    logic        sol;
    logic        eol;
  } win_t;

  win_t gotQ[$];
  int   assertCount = 0;
  int   failCount = 0;

  localparam logic [15:0] WEXP [4] = '{16'h0070, 16'h946B, 16'h9559, 16'hB649};
  localparam logic [35:0] BASIC [4] = '{
    {9'h030, 9'h020, 9'h010, 9'h010},
    {9'h040, 9'h030, 9'h020, 9'h010},
    {9'h040, 9'h040, 9'h030, 9'h020},
    {9'h040, 9'h040, 9'h040, 9'h030}
  };

  logic [8:0] lineDrop [8] = '{9'h001, 9'h002, 9'h003, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
  logic [8:0] lineNew  [8] = '{9'h00A, 9'h00B, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
  logic [8:0] lineA    [8] = '{9'h101, 9'h002, 9'h1F3, 9'h044, 9'h085, 9'h000, 9'h000, 9'h000};
  logic [8:0] lineB    [8] = '{9'h0AA, 9'h155, 9'h0CC, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};

  bicubic_tap_window #(
    .SCALE(4),
    .PIX_W(9)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sol      (in_sol),
    .in_eol      (in_eol),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pixels  (out_pixels),
    .out_weights (out_weights),
    .out_phase   (out_phase),
    .out_sol     (out_sol),
    .out_eol     (out_eol)
`ifdef BICUBIC_TAP_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Record every window the downstream side actually takes.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      gotQ.push_back({out_pixels, out_weights, out_phase, out_sol, out_eol});
    end
  end

  // Hard stop in case something outside the bounded waits hangs.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Reference window for centre c of an n-pixel line with edge replication.
  function automatic logic [35:0] expPix(input logic [8:0] ln [8], input int n, input int c);
    int im1;
    int ip1;
    int ip2;
    im1 = (c == 0) ? 0 : c - 1;
    ip1 = (c + 1 > n - 1) ? n - 1 : c + 1;
    ip2 = (c + 2 > n - 1) ? n - 1 : c + 2;
    return {ln[ip2], ln[ip1], ln[c], ln[im1]};
  endfunction

  // Put the DUT through reset and leave it idle with downstream ready.
  task automatic doReset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sol = 1'b0;
    in_eol = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gotQ.delete();
  endtask

  // Offer one pixel and hold it until accepted or the cycle budget runs out.
  task automatic sendPixel(input logic [8:0] d, input logic s, input logic e);
    bit done;
    done = 1'b0;
    in_data = d;
    in_sol = s;
    in_eol = e;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_sol = 1'b0;
    in_eol = 1'b0;
    assertCount++;
    if (!done) begin
      failCount++;
      $display("[TB] FAIL send_timeout: pixel %h accepted=%0d required=1", d, done);
    end
  endtask

  // Wait for n windows, let a few more cycles pass, then demand exactly n.
  task automatic waitWindows(input int n, input string name);
    for (int i = 0; i < 3000 && gotQ.size() < n; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    assertCount++;
    if (gotQ.size() != n) begin
      failCount++;
      $display("[TB] FAIL %s: windows got %0d required %0d", name, gotQ.size(), n);
    end
  endtask

  // Reset values of every output while reset is held.
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    assertCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    assertCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
    assertCount++; if (out_sol !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_sol: got %b required 0", out_sol); end
    assertCount++; if (out_eol !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_eol: got %b required 0", out_eol); end
    assertCount++; if (out_pixels !== 36'h0) begin failCount++; $display("[TB] FAIL reset_out_pixels: got %h required 0", out_pixels); end
    assertCount++; if (out_weights !== 16'h0) begin failCount++; $display("[TB] FAIL reset_out_weights: got %h required 0", out_weights); end
    assertCount++; if (out_phase !== 3'd0) begin failCount++; $display("[TB] FAIL reset_out_phase: got %0d required 0", out_phase); end
    rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  // Four-pixel line with downstream always ready, plus first-window latency.
  task automatic test_basic_line();
    win_t act;
    win_t exp;
    doReset();
    sendPixel(9'h010, 1'b1, 1'b0);
    sendPixel(9'h020, 1'b0, 1'b0);
    sendPixel(9'h030, 1'b0, 1'b0);
    assertCount++;
    if (out_valid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL basic_latency: out_valid got %b required 1", out_valid);
    end
    sendPixel(9'h040, 1'b0, 1'b1);
    waitWindows(16, "basic_count");
    for (int k = 0; k < 16; k++) begin
      act = (k < gotQ.size()) ? gotQ[k] : 'x;
      exp = '{pix: BASIC[k/4], wgt: WEXP[k%4], ph: 3'(k%4), sol: (k == 0), eol: (k == 15)};
      assertCount++;
      if (act !== exp) begin
        failCount++;
        $display("[TB] FAIL basic_win[%0d]: got %h required %h", k, act, exp);
      end
    end
  endtask

  // One-pixel line: both edges replicate the only pixel, one centre results.
  task automatic test_single_pixel();
    win_t act;
    win_t exp;
    doReset();
    sendPixel(9'h1FF, 1'b1, 1'b1);
    waitWindows(4, "single_count");
    for (int k = 0; k < 4; k++) begin
      act = (k < gotQ.size()) ? gotQ[k] : 'x;
      exp = '{pix: {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}, wgt: WEXP[k], ph: 3'(k), sol: (k == 0), eol: (k == 3)};
      assertCount++;
      if (act !== exp) begin
        failCount++;
        $display("[TB] FAIL single_win[%0d]: got %h required %h", k, act, exp);
      end
    end
  endtask

  // Downstream stalls five cycles at phase 2 of the first centre.
  task automatic test_stall();
    win_t act;
    win_t exp;
    doReset();
    fork
      begin
        sendPixel(9'h010, 1'b1, 1'b0);
        sendPixel(9'h020, 1'b0, 1'b0);
        sendPixel(9'h030, 1'b0, 1'b0);
        sendPixel(9'h040, 1'b0, 1'b1);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
          @(negedge clk);
          if (out_valid && out_ready && out_phase == 3'd1) seen = 1'b1;
        end
        assertCount++;
        if (!seen) begin
          failCount++;
          $display("[TB] FAIL stall_reach_phase1: seen %0d required 1", seen);
        end else begin
          @(posedge clk);
          #1;
          out_ready = 1'b0;
          for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            assertCount++;
            if ({out_valid, out_pixels, out_weights, out_phase} !== {1'b1, BASIC[0], 16'h9559, 3'd2}) begin
              failCount++;
              $display("[TB] FAIL stall_hold[%0d]: got %h required %h", c,
                       {out_valid, out_pixels, out_weights, out_phase}, {1'b1, BASIC[0], 16'h9559, 3'd2});
            end
          end
          @(posedge clk);
          #1;
          out_ready = 1'b1;
        end
      end
    join
    waitWindows(16, "stall_count");
    for (int k = 0; k < 16; k++) begin
      act = (k < gotQ.size()) ? gotQ[k] : 'x;
      exp = '{pix: BASIC[k/4], wgt: WEXP[k%4], ph: 3'(k%4), sol: (k == 0), eol: (k == 15)};
      assertCount++;
      if (act !== exp) begin
        failCount++;
        $display("[TB] FAIL stall_win[%0d]: got %h required %h", k, act, exp);
      end
    end
`ifdef BICUBIC_TAP_STALL_CNT_EN
    assertCount++;
    if (stall_cnt !== 16'd5) begin
      failCount++;
      $display("[TB] FAIL stall_cnt: got %0d required 5", stall_cnt);
    end
`endif
  endtask

  // A pixel without start-of-line after reset is swallowed; the next line is normal.
  task automatic test_drop_no_sol();
    win_t act;
    win_t exp;
    bit anyValid;
    doReset();
    sendPixel(9'h055, 1'b0, 1'b0);
    anyValid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) anyValid = 1'b1;
    end
    assertCount++;
    if (anyValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL drop_no_valid: out_valid seen %b required 0", anyValid);
    end
    sendPixel(9'h001, 1'b1, 1'b0);
    sendPixel(9'h002, 1'b0, 1'b0);
    sendPixel(9'h003, 1'b0, 1'b1);
    waitWindows(12, "drop_count");
    for (int k = 0; k < 12; k++) begin
      act = (k < gotQ.size()) ? gotQ[k] : 'x;
      exp = '{pix: expPix(lineDrop, 3, k/4), wgt: WEXP[k%4], ph: 3'(k%4), sol: (k == 0), eol: (k == 11)};
      assertCount++;
      if (act !== exp) begin
        failCount++;
        $display("[TB] FAIL drop_win[%0d]: got %h required %h", k, act, exp);
      end
    end
  endtask

  // Reset asserted during phase 1 of centre 2 discards the line.
  task automatic test_reset_mid_emit();
    win_t act;
    win_t exp;
    bit anyEol;
    bit anyValid;
    doReset();
    fork
      begin
        sendPixel(9'h010, 1'b1, 1'b0);
        sendPixel(9'h020, 1'b0, 1'b0);
        sendPixel(9'h030, 1'b0, 1'b0);
        sendPixel(9'h040, 1'b0, 1'b1);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
          @(negedge clk);
          if (out_valid && out_phase == 3'd1 && out_pixels == BASIC[2]) seen = 1'b1;
        end
        assertCount++;
        if (!seen) begin
          failCount++;
          $display("[TB] FAIL rstmid_reach: seen %0d required 1", seen);
        end
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        assertCount++;
        if ({out_valid, in_ready, out_sol, out_eol, out_phase} !== {1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
          failCount++;
          $display("[TB] FAIL rstmid_state: valid/ready/sol/eol/phase got %b required %b",
                   {out_valid, in_ready, out_sol, out_eol, out_phase}, {1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
        end
        rst_n = 1'b1;
      end
    join
    anyEol = 1'b0;
    foreach (gotQ[i]) if (gotQ[i].eol) anyEol = 1'b1;
    assertCount++;
    if (anyEol !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rstmid_no_eol: eol seen %b required 0", anyEol);
    end
    gotQ.delete();
    sendPixel(9'h0EE, 1'b0, 1'b0);
    anyValid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) anyValid = 1'b1;
    end
    assertCount++;
    if (anyValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rstmid_fill_cleared: out_valid seen %b required 0", anyValid);
    end
    sendPixel(9'h00A, 1'b1, 1'b0);
    sendPixel(9'h00B, 1'b0, 1'b1);
    waitWindows(8, "rstmid_count");
    for (int k = 0; k < 8; k++) begin
      act = (k < gotQ.size()) ? gotQ[k] : 'x;
      exp = '{pix: expPix(lineNew, 2, k/4), wgt: WEXP[k%4], ph: 3'(k%4), sol: (k == 0), eol: (k == 7)};
      assertCount++;
      if (act !== exp) begin
        failCount++;
        $display("[TB] FAIL rstmid_win[%0d]: got %h required %h", k, act, exp);
      end
    end
  endtask

  // Two lines back to back under random downstream backpressure.
  task automatic test_back_to_back();
    win_t act;
    win_t exp;
    int solCount;
    int eolCount;
    doReset();
    fork
      begin
        for (int i = 0; i < 5; i++) sendPixel(lineA[i], (i == 0), (i == 4));
        for (int i = 0; i < 3; i++) sendPixel(lineB[i], (i == 0), (i == 2));
      end
      begin
        for (int i = 0; i < 3000 && gotQ.size() < 32; i++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    waitWindows(32, "b2b_count");
    solCount = 0;
    eolCount = 0;
    for (int k = 0; k < 32; k++) begin
      act = (k < gotQ.size()) ? gotQ[k] : 'x;
      if (k < 20) begin
        exp = '{pix: expPix(lineA, 5, k/4), wgt: WEXP[k%4], ph: 3'(k%4), sol: (k == 0), eol: (k == 19)};
      end else begin
        exp = '{pix: expPix(lineB, 3, (k-20)/4), wgt: WEXP[k%4], ph: 3'(k%4), sol: (k == 20), eol: (k == 31)};
      end
      if (act.sol === 1'b1) solCount++;
      if (act.eol === 1'b1) eolCount++;
      assertCount++;
      if (act !== exp) begin
        failCount++;
        $display("[TB] FAIL b2b_win[%0d]: got %h required %h", k, act, exp);
      end
    end
    assertCount++;
    if (solCount != 2) begin
      failCount++;
      $display("[TB] FAIL b2b_sol_count: got %0d required 2", solCount);
    end
    assertCount++;
    if (eolCount != 2) begin
      failCount++;
      $display("[TB] FAIL b2b_eol_count: got %0d required 2", eolCount);
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    test_reset();
    test_basic_line();
    test_single_pixel();
    test_stall();
    test_drop_no_sol();
    test_reset_mid_emit();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
